tof_trigger_timer: RTL and testbench
====================================

# tof_trigger_timer

Time-of-flight trigger/capture engine between the MuraxCustom SoC and the board trigger pins. On a start command it drives a fixed-width pulse on selected trigger outputs. It then timestamps the first rising edge on each of two asynchronous trigger inputs with a free-running measurement counter. The capture ends when both edges arrive or a programmable timeout expires, and the result is offered to the SoC peripheral over a valid/ready handshake.

## Interface
- CNT_WIDTH, 16, width of measurement counter, stamps and timeout
- PULSE_LEN, 4, trigger pulse length in clock cycles (>=1)
- SYNC_STAGES, 2, flip-flop stages on each trigger input (>=2)

Ports:
- io_mainClk  in  1  sole clock
- io_asyncReset_n  in  1  reset, asynchronous assert, active-low
- io_start  in  1  single-cycle start request; honoured only when io_busy=0
- io_outMask  in  3  trigger outputs to pulse; sampled with io_start
- io_timeout  in  CNT_WIDTH  capture window in cycles; sampled with io_start; 0 means 2^CNT_WIDTH-1
- io_busy  out  1  high from the cycle after an accepted start until the result is taken
- io_trigsOut  out  3  trigger pulses to pins
- io_trigsIn  in  2  asynchronous trigger inputs from pins
- io_result_valid  out  1  result available
- io_result_ready  in  1  consumer accepts result
- io_result_stamp0  out  CNT_WIDTH  counter value at the first edge on io_trigsIn[0]
- io_result_stamp1  out  CNT_WIDTH  counter value at the first edge on io_trigsIn[1]
- io_result_hit  out  2  per-channel edge-captured flags
- io_result_timeout  out  1  window expired before both channels hit

## Operation
- States: IDLE, PULSE, WAIT, DONE.
- IDLE: io_start=1 latches mask and timeout, clears stamps and hits, loads the pulse counter, clears the measurement counter, then goes to PULSE.
- PULSE: io_trigsOut = latched mask for exactly PULSE_LEN cycles. The measurement counter runs from 0 in the first PULSE cycle. Edge capture is already active. After PULSE_LEN cycles, go to WAIT.
- WAIT: counter keeps incrementing and capture continues.
  - Both hits set: go to DONE.
  - Otherwise, counter == latched timeout: go to DONE with io_result_timeout=1.
- Edge detect: a rising edge is synced=1 while the previous synced sample=0. A channel that is already high at start does not hit until it goes low and then high again.
- First edge only: when a channel's hit is 0 and an edge is detected, stamp = current counter value and hit is set. Later edges on that channel are ignored.
- DONE: io_result_valid=1. All result outputs are held stable until io_result_valid and io_result_ready are both high in the same cycle, then go to IDLE.
- io_busy = (state != IDLE).
- io_start is ignored in PULSE, WAIT and DONE, including the DONE handshake cycle.
- The counter never wraps within a capture, because the timeout is at most 2^CNT_WIDTH-1.

## Timing
- Reset values of all outputs are 0: io_trigsOut, io_busy, io_result_* (stamps, hits, timeout). The state returns to IDLE.
- Reset mid-capture aborts immediately. io_trigsOut drops asynchronously and no result is produced.
- io_start high in cycle 0 gives io_trigsOut high in cycles 1..PULSE_LEN, with counter=0 in cycle 1.
- Input latency: a pin edge becomes an edge-detect SYNC_STAGES+1 cycles later. Stamps are not compensated for this latency.
- Edge detected in the same cycle the counter reaches the timeout: the edge is stamped. If that completes both hits, io_result_timeout=0.
- Both channels' edges detected in the same cycle: both stamped with the same value.
- Completion cycle T (last hit or timeout) gives io_result_valid=1 from cycle T+1.
- Handshake in cycle H gives io_result_valid=0 and io_busy=0 in H+1. A new start is accepted from H+1.

## Test plan
- Basic capture: PULSE_LEN=4, SYNC_STAGES=2, mask=3'b101, timeout=100. Drive in0 high 20 cycles after the start cycle and in1 high 35 cycles after. Required: trigsOut[0] and trigsOut[2] high for 4 cycles, trigsOut[1] never high; stamp0=22, stamp1=37, hit=2'b11, timeout=0.
- Timeout: timeout=50, only in0 toggles, at cycle 10. Required: hit=2'b01, stamp0=12, timeout=1, valid asserted on the cycle after the counter reaches 50.
- Pre-high input: in1 held high through start, then low at 30 and high at 40. Required: stamp1 reflects the edge at 40, not the start.
- Back-pressure and busy: hold ready=0 for 20 cycles and pulse io_start during DONE. Required: results stable, start ignored; ready=1 releases the result, and a start in the next cycle is accepted.
- Simultaneous events: both inputs rise in the same cycle, landing on the timeout count. Required: equal stamps, hit=2'b11, timeout=0.
- Reset mid-WAIT: assert io_asyncReset_n=0 during capture. Required: all outputs 0 immediately; after release, a fresh capture completes normally.

Source files
------------

// File: rtl/tof_trigger_timer.sv
// Time-of-flight trigger/capture engine: pulses selected trigger pins on start, then
// stamps the first rising edge on each of two asynchronous inputs until both hit or a timeout.
module tof_trigger_timer #(
  parameter int CNT_WIDTH   = 16,
  parameter int PULSE_LEN   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 io_mainClk,
  input  logic                 io_asyncReset_n,
  input  logic                 io_start,
  input  logic [2:0]           io_outMask,
  input  logic [CNT_WIDTH-1:0] io_timeout,
  output logic                 io_busy,
  output logic [2:0]           io_trigsOut,
  input  logic [1:0]           io_trigsIn,
  output logic                 io_result_valid,
  input  logic                 io_result_ready,
  output logic [CNT_WIDTH-1:0] io_result_stamp0,
  output logic [CNT_WIDTH-1:0] io_result_stamp1,
  output logic [1:0]           io_result_hit,
  output logic                 io_result_timeout
);

  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [PW-1:0]        PLOAD   = PW'(PULSE_LEN - 1);
  localparam logic [PW-1:0]        PONE    = PW'(1'b1);
  localparam logic [PW-1:0]        PZERO   = {PW{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r, state_nx;
  logic [2:0]             mask_r, mask_nx;
  logic [CNT_WIDTH-1:0]   tmo_r, tmo_nx;
  logic [CNT_WIDTH-1:0]   cnt_r, cnt_nx;
  logic [PW-1:0]          pcnt_r, pcnt_nx;
  logic [CNT_WIDTH-1:0]   stamp0_r, stamp0_nx;
  logic [CNT_WIDTH-1:0]   stamp1_r, stamp1_nx;
  logic [1:0]             hit_r, hit_nx;
  logic                   tflag_r, tflag_nx;
  logic [2:0]             trig_r, trig_nx;
  logic                   busy_r, valid_r;
  logic [SYNC_STAGES-1:0] sa_r, sb_r;
  logic [1:0]             sync_s, prev_r, edge_r, new_hit_s;

  assign sync_s    = {sb_r[SYNC_STAGES-1], sa_r[SYNC_STAGES-1]};
  assign new_hit_s = edge_r & ~hit_r;

  // Input synchronizers and registered rising-edge detect (SYNC_STAGES+1 cycles pin-to-edge).
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      sa_r   <= {SYNC_STAGES{1'b0}};
      sb_r   <= {SYNC_STAGES{1'b0}};
      prev_r <= 2'b00;
      edge_r <= 2'b00;
    end else begin
      sa_r   <= {sa_r[SYNC_STAGES-2:0], io_trigsIn[0]};
      sb_r   <= {sb_r[SYNC_STAGES-2:0], io_trigsIn[1]};
      prev_r <= sync_s;
      edge_r <= sync_s & ~prev_r;
    end
  end

  // State register.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, counters and capture logic.
  always_comb begin
    state_nx  = state_r;
    mask_nx   = mask_r;
    tmo_nx    = tmo_r;
    cnt_nx    = cnt_r;
    pcnt_nx   = pcnt_r;
    stamp0_nx = stamp0_r;
    stamp1_nx = stamp1_r;
    hit_nx    = hit_r;
    tflag_nx  = tflag_r;
    trig_nx   = 3'b000;
    case (state_r)
      IDLE: begin
        if (io_start) begin
          state_nx  = PULSE;
          mask_nx   = io_outMask;
          tmo_nx    = (io_timeout == CNT_ZERO) ? CNT_MAX : io_timeout;
          cnt_nx    = CNT_ZERO;
          pcnt_nx   = PLOAD;
          stamp0_nx = CNT_ZERO;
          stamp1_nx = CNT_ZERO;
          hit_nx    = 2'b00;
          tflag_nx  = 1'b0;
          trig_nx   = io_outMask;
        end else begin
          state_nx = IDLE;
        end
      end
      PULSE, WAIT: begin
        cnt_nx = cnt_r + CNT_ONE;
        hit_nx = hit_r | edge_r;
        if (new_hit_s[0]) begin
          stamp0_nx = cnt_r;
        end else begin
          stamp0_nx = stamp0_r;
        end
        if (new_hit_s[1]) begin
          stamp1_nx = cnt_r;
        end else begin
          stamp1_nx = stamp1_r;
        end
        if (state_r == PULSE) begin
          if (pcnt_r == PZERO) begin
            state_nx = WAIT;
          end else begin
            pcnt_nx = pcnt_r - PONE;
            trig_nx = mask_r;
          end
        end else begin
          // A timeout shorter than the pulse still ends the window on the first WAIT cycle.
          if (hit_nx == 2'b11) begin
            state_nx = DONE;
          end else if (cnt_r >= tmo_r) begin
            state_nx = DONE;
            tflag_nx = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      DONE: begin
        if (io_result_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      mask_r   <= 3'b000;
      tmo_r    <= CNT_ZERO;
      cnt_r    <= CNT_ZERO;
      pcnt_r   <= PZERO;
      stamp0_r <= CNT_ZERO;
      stamp1_r <= CNT_ZERO;
      hit_r    <= 2'b00;
      tflag_r  <= 1'b0;
      trig_r   <= 3'b000;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      mask_r   <= mask_nx;
      tmo_r    <= tmo_nx;
      cnt_r    <= cnt_nx;
      pcnt_r   <= pcnt_nx;
      stamp0_r <= stamp0_nx;
      stamp1_r <= stamp1_nx;
      hit_r    <= hit_nx;
      tflag_r  <= tflag_nx;
      trig_r   <= trig_nx;
      busy_r   <= (state_nx != IDLE);
      valid_r  <= (state_nx == DONE);
    end
  end

  assign io_busy           = busy_r;
  assign io_trigsOut       = trig_r;
  assign io_result_valid   = valid_r;
  assign io_result_stamp0  = stamp0_r;
  assign io_result_stamp1  = stamp1_r;
  assign io_result_hit     = hit_r;
  assign io_result_timeout = tflag_r;

endmodule

// File: tb/tb_tof_trigger_timer.sv
// Randomized and directed bench for tof_trigger_timer against a cycle-indexed
// reference model computed from pin waveforms, pulse length and timeout.
module tb_tof_trigger_timer;

  localparam int CW    = 16;
  localparam int PL    = 4;
  localparam int LAT   = 3;  // pin edge to detect: SYNC_STAGES + 1
  localparam int NEVER = 1000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    mask_in = 3'b000;
  logic [CW-1:0] tmo_in = 16'd0;
  logic [1:0]    pins = 2'b00;
  logic          ready = 1'b0;
  logic          busy, valid, tflag;
  logic [2:0]    trigs;
  logic [CW-1:0] stamp0, stamp1;
  logic [1:0]    hit;

  int n_cmp = 0;
  int n_err = 0;

  tof_trigger_timer #(.CNT_WIDTH(CW), .PULSE_LEN(PL), .SYNC_STAGES(2)) dut (
    .io_mainClk(clk),
    .io_asyncReset_n(rst_n),
    .io_start(start),
    .io_outMask(mask_in),
    .io_timeout(tmo_in),
    .io_busy(busy),
    .io_trigsOut(trigs),
    .io_trigsIn(pins),
    .io_result_valid(valid),
    .io_result_ready(ready),
    .io_result_stamp0(stamp0),
    .io_result_stamp1(stamp1),
    .io_result_hit(hit),
    .io_result_timeout(tflag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic lvl(input logic init, input int ta, input int tb, input int c);
    return init ^ (c >= ta) ^ (c >= tb);
  endfunction

  // First cycle (relative to start cycle 0) at which a rising pin edge is detected.
  function automatic int first_det(input logic init, input int ta, input int tb, input int lim);
    for (int c = 1; c <= lim; c++) begin
      if (lvl(init, ta, tb, c) && !lvl(init, ta, tb, c - 1)) return c + LAT;
    end
    return NEVER;
  endfunction

  task automatic run_trial(input logic [2:0] mask, input int tmo, input logic [1:0] init,
                           input int ta0, input int tb0, input int ta1, input int tb1,
                           input int bp, input int pre, input int abort_at);
    int d0, d1, tt, tb, tend, h;
    logic [1:0] ehit;
    logic eflag;
    int es0, es1;
    logic [4:0] ectl;
    logic [34:0] eres;
    // Pins settle at their start level while the engine idles.
    for (int g = 0; g < pre; g++) begin
      @(posedge clk); #1;
      pins = init; start = 1'b0; ready = 1'($urandom_range(0, 1));
      check_val("idle_ctl", 64'({trigs, busy, valid}), 64'(5'b00000));
    end
    d0   = first_det(init[0], ta0, tb0, tmo + 10);
    d1   = first_det(init[1], ta1, tb1, tmo + 10);
    tt   = tmo + 1;
    tb   = (d0 > d1) ? d0 : d1;
    tb   = (tb > PL + 1) ? tb : PL + 1;
    tend = (tb < tt) ? tb : tt;
    ehit = {1'(d1 <= tend), 1'(d0 <= tend)};
    eflag = (ehit != 2'b11);
    es0  = ehit[0] ? d0 - 1 : 0;
    es1  = ehit[1] ? d1 - 1 : 0;
    eres = {CW'(es0), CW'(es1), ehit, eflag};
    h    = tend + 1 + bp;
    for (int c = 0; c <= h; c++) begin
      @(posedge clk); #1;
      pins = {lvl(init[1], ta1, tb1, c), lvl(init[0], ta0, tb0, c)};
      if (c == 0) begin
        start = 1'b1; mask_in = mask; tmo_in = CW'(tmo); ready = 1'b0;
        ectl = 5'b00000;
      end else begin
        start = 1'($urandom_range(0, 1));
        mask_in = 3'($urandom); tmo_in = CW'($urandom);
        if (c < tend + 1) ready = 1'($urandom_range(0, 1));
        else ready = (c == h);
        ectl = {((c <= PL) ? mask : 3'b000), 1'b1, 1'(c >= tend + 1)};
      end
      check_val("ctl", 64'({trigs, busy, valid}), 64'(ectl));
      if (c == tend + 1 || c == h)
        check_val("result", 64'({stamp0, stamp1, hit, tflag}), 64'(eres));
      if (c == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_val("abort_zero", 64'({trigs, busy, valid, stamp0, stamp1, hit, tflag}), 64'(0));
        start = 1'b0; ready = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int tmo, ta0, tb0, ta1, tb1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_val("reset", 64'({trigs, busy, valid, stamp0, stamp1, hit, tflag}), 64'(0));
    rst_n = 1'b1;

    run_trial(3'b101, 100, 2'b00, 20, NEVER, 35, NEVER, 2, 5, -1);    // basic: 22/37
    run_trial(3'b010, 50, 2'b00, 10, NEVER, NEVER, NEVER, 1, 5, -1);  // timeout
    run_trial(3'b111, 100, 2'b10, 8, NEVER, 30, 40, 0, 5, -1);        // in1 pre-high
    run_trial(3'b011, 60, 2'b00, 10, NEVER, 15, NEVER, 20, 5, -1);    // back-pressure
    run_trial(3'b100, 30, 2'b11, 5, 12, NEVER, NEVER, 0, 0, -1);      // start right after H
    run_trial(3'b001, 40, 2'b00, 38, NEVER, 38, NEVER, 0, 5, -1);     // both on timeout count
    run_trial(3'b111, 80, 2'b00, 30, NEVER, 40, NEVER, 0, 5, 20);     // reset mid-WAIT
    run_trial(3'b111, 80, 2'b00, 30, NEVER, 40, NEVER, 0, 5, 2);      // reset mid-PULSE
    run_trial(3'b101, 100, 2'b00, 20, NEVER, 35, NEVER, 1, 5, -1);    // fresh capture

    for (int t = 0; t < 40; t++) begin
      tmo = int'($urandom_range(PL, 90));
      ta0 = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, tmo + 6));
      tb0 = (ta0 == NEVER || $urandom_range(0, 1) == 0) ? NEVER : ta0 + int'($urandom_range(1, 30));
      ta1 = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, tmo + 6));
      tb1 = (ta1 == NEVER || $urandom_range(0, 1) == 0) ? NEVER : ta1 + int'($urandom_range(1, 30));
      run_trial(3'($urandom), tmo, 2'($urandom), ta0, tb0, ta1, tb1,
                int'($urandom_range(0, 4)), 5, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
